subservient_sram_ctrl: RTL and testbench
========================================

Name: subservient_sram_ctrl

Overview:
- Arbitrating controller for the byte-wide SRAM of the subservient SoC.
- Accepts 32-bit Wishbone classic accesses from two requesters: port A (CPU memory bus) and port B (debug bus).
- Round-robin arbitration between the two ports.
- Serialises each granted access into four sequential byte operations on the single-port-style SRAM write/read interface.

Parameters:
- memsize, 512, SRAM size in bytes (power of two, at least 4).
- aw, $clog2(memsize), SRAM byte-address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_a_adr  in  32  port A byte address; bits [1:0] ignored
- i_wb_a_dat  in  32  port A write data
- i_wb_a_sel  in  4  port A byte enables
- i_wb_a_we  in  1  port A write
- i_wb_a_stb  in  1  port A strobe
- o_wb_a_rdt  out  32  read data (shared register)
- o_wb_a_ack  out  1  port A acknowledge
- i_wb_b_adr / i_wb_b_dat / i_wb_b_sel / i_wb_b_we / i_wb_b_stb  in  32/32/4/1/1  port B, same meaning as port A
- o_wb_b_rdt  out  32  read data (same register as o_wb_a_rdt)
- o_wb_b_ack  out  1  port B acknowledge
- o_sram_waddr  out  aw  SRAM write address
- o_sram_wdata  out  8  SRAM write data
- o_sram_wen  out  1  SRAM write enable
- o_sram_raddr  out  aw  SRAM read address
- i_sram_rdata  in  8  SRAM read data, valid one cycle after o_sram_ren
- o_sram_ren  out  1  SRAM read enable

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; rdt register 0; cnt 0; last_grant = B, so A wins the first tie.
- Reset asserted mid-transaction: wen/ren/ack drop immediately. The aborted access is not acked. Bytes already written stay written.
- States: IDLE, WRITE, READ, RLAST, ACK.
- IDLE:
  - If only one stb is high, grant that port. If both are high, grant the port not equal to last_grant.
  - On grant: latch adr[aw-1:2], dat, sel, we; set last_grant; set cnt = 0; go to WRITE (we = 1) or READ (we = 0).
  - No stb: stay in IDLE.
- WRITE, cnt = 0..3, one byte per cycle, ascending:
  - o_sram_waddr = {adr_q[aw-1:2], cnt}
  - o_sram_wdata = dat_q[8*cnt+7 : 8*cnt]
  - o_sram_wen = sel_q[cnt]
  - Unselected bytes take a cycle with wen = 0, so the byte count is fixed.
  - After cnt = 3, go to ACK.
- READ, cnt = 0..3:
  - o_sram_ren = 1; o_sram_raddr = {adr_q[aw-1:2], cnt}.
  - When cnt > 0, capture i_sram_rdata into rdt[8*(cnt-1) +: 8].
  - After cnt = 3, go to RLAST.
  - sel is ignored on reads; all four bytes are fetched.
- RLAST: ren = 0; capture i_sram_rdata into rdt[31:24]; go to ACK.
- ACK:
  - Assert the granted port's ack for exactly one cycle; o_wb_x_rdt holds the assembled word.
  - The other port's ack stays 0.
  - Go to IDLE unconditionally.
  - IDLE lasts at least one cycle, so a requester that drops stb after seeing ack is never re-granted spuriously.
- Latency, measured from the IDLE cycle that samples stb:
  - Write: ack in cycle 5.
  - Read: ack in cycle 6.
- rdt register: updated only during READ/RLAST; holds its value otherwise; wired to both ports. Valid only while that port's ack = 1.
- Waiting port: held off with no ack and no state change until the controller returns to IDLE.
- Requester drops stb mid-transaction: the transaction completes, including all SRAM writes, and ack is still pulsed.
- Address bits above aw-1 are ignored, so accesses alias modulo memsize.
- o_sram_wen and o_sram_ren are never high in the same cycle.
- cnt is 2 bits wide and wraps naturally.
- Unused address outputs hold their last value. They carry meaning only while the matching enable is high.

Test Plan:
- Reset, then port A write: adr = 0x10, dat = 0xA1B2C3D4, sel = 0xF → wen pulses in 4 consecutive cycles; waddr 0x10..0x13; wdata D4, C3, B2, A1; ack_a in cycle 5; ack_b stays 0.
- Port A read of adr = 0x10 after the above, using an SRAM model with 1-cycle read latency → ren for 4 cycles, raddr 0x10..0x13; ack_a in cycle 6 with rdt = 0xA1B2C3D4.
- Partial write: sel = 0x5, dat = 0x11223344, adr = 0x20 → wen only for addresses 0x20 and 0x22 (data 44, 22); read back of 0x20 yields 0x??22??44 with the untouched bytes preserved; ack still in cycle 5.
- Both stb high continuously from reset → grants in order A, B, A, B; each ack goes only to the granted port; at least one IDLE cycle between transactions.
- Assert i_rst_n low during the second WRITE cycle → wen = 0 and ack = 0 immediately; after release, state is IDLE, last_grant = B, and a fresh access completes normally.
- Port B write with adr = 0x0000_0204 and memsize = 512 → waddr 0x004..0x007 (aliasing).

Source files
------------

// File: rtl/subservient_sram_ctrl.sv
// Two-port Wishbone-to-byte-SRAM controller for the subservient SoC.
// Port A (CPU) and port B (debug) share one byte-wide SRAM through a
// round-robin arbiter; every 32-bit access becomes four byte cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | wait for a strobe, arbitrate, latch the request
// WRITE  | one byte per cycle, cnt 0..3, wen follows the byte enable
// READ   | one byte read per cycle, cnt 0..3, capture previous byte
// RLAST  | capture the final read byte (SRAM has one cycle latency)
// ACK    | one-cycle acknowledge to the granted port
module subservient_sram_ctrl #(
    parameter int memsize = 512,
    parameter int aw      = $clog2(memsize)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_wb_a_adr,
    input  logic [31:0]   i_wb_a_dat,
    input  logic [3:0]    i_wb_a_sel,
    input  logic          i_wb_a_we,
    input  logic          i_wb_a_stb,
    output logic [31:0]   o_wb_a_rdt,
    output logic          o_wb_a_ack,
    input  logic [31:0]   i_wb_b_adr,
    input  logic [31:0]   i_wb_b_dat,
    input  logic [3:0]    i_wb_b_sel,
    input  logic          i_wb_b_we,
    input  logic          i_wb_b_stb,
    output logic [31:0]   o_wb_b_rdt,
    output logic          o_wb_b_ack,
    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    input  logic [7:0]    i_sram_rdata,
    output logic          o_sram_ren
);

    // Word-address width; kept at least one bit so a 4-byte SRAM still elaborates.
    localparam int PW = (aw > 2) ? aw - 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RLAST,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] page_q, page_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          last_grant_q, last_grant_d;   // 1 = port B
    logic [31:0]   rdt_q, rdt_d;
    logic [aw-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wen_q, wen_d;
    logic [aw-1:0] raddr_q, raddr_d;
    logic          ren_q, ren_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          pick_b;

    // Address bits outside the SRAM word range are deliberately ignored (aliasing).
    logic unused_adr;
    assign unused_adr = ^{i_wb_a_adr[31:aw], i_wb_a_adr[1:0],
                          i_wb_b_adr[31:aw], i_wb_b_adr[1:0]};

    function automatic logic [aw-1:0] byte_addr(input logic [PW-1:0] p, input logic [1:0] c);
        logic [PW+1:0] full;
        full = {p, c};
        return full[aw-1:0];
    endfunction

    // Next-state logic; SRAM and ack outputs are derived from the next state so they leave flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        page_d       = page_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        rdt_d        = rdt_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        raddr_d      = raddr_q;
        wen_d        = 1'b0;
        ren_d        = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        pick_b       = i_wb_b_stb && (!i_wb_a_stb || !last_grant_q);

        case (state_q)
            S_IDLE: begin
                if (i_wb_a_stb || i_wb_b_stb) begin
                    last_grant_d = pick_b;
                    cnt_d        = 2'd0;
                    if (pick_b) begin
                        page_d  = i_wb_b_adr[PW+1:2];
                        dat_d   = i_wb_b_dat;
                        sel_d   = i_wb_b_sel;
                        state_d = i_wb_b_we ? S_WRITE : S_READ;
                    end else begin
                        page_d  = i_wb_a_adr[PW+1:2];
                        dat_d   = i_wb_a_dat;
                        sel_d   = i_wb_a_sel;
                        state_d = i_wb_a_we ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_ACK;
            end
            S_READ: begin
                cnt_d = cnt_q + 2'd1;
                case (cnt_q)
                    2'd1:    rdt_d[7:0]   = i_sram_rdata;
                    2'd2:    rdt_d[15:8]  = i_sram_rdata;
                    2'd3:    rdt_d[23:16] = i_sram_rdata;
                    default: ;
                endcase
                if (cnt_q == 2'd3) state_d = S_RLAST;
            end
            S_RLAST: begin
                rdt_d[31:24] = i_sram_rdata;
                state_d      = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_WRITE) begin
            wen_d   = sel_d[cnt_d];
            waddr_d = byte_addr(page_d, cnt_d);
            wdata_d = dat_d[{cnt_d, 3'b000} +: 8];
        end
        if (state_d == S_READ) begin
            ren_d   = 1'b1;
            raddr_d = byte_addr(page_d, cnt_d);
        end
        if (state_d == S_ACK) begin
            ack_a_d = !last_grant_d;
            ack_b_d = last_grant_d;
        end
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            page_q       <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            last_grant_q <= 1'b1;
            rdt_q        <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            raddr_q      <= '0;
            ren_q        <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            page_q       <= page_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            rdt_q        <= rdt_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            raddr_q      <= raddr_d;
            ren_q        <= ren_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
        end
    end

    assign o_wb_a_rdt   = rdt_q;
    assign o_wb_b_rdt   = rdt_q;
    assign o_wb_a_ack   = ack_a_q;
    assign o_wb_b_ack   = ack_b_q;
    assign o_sram_waddr = waddr_q;
    assign o_sram_wdata = wdata_q;
    assign o_sram_wen   = wen_q;
    assign o_sram_raddr = raddr_q;
    assign o_sram_ren   = ren_q;

endmodule

// File: tb/tb_subservient_sram_ctrl.sv
// Bench for subservient_sram_ctrl: byte-SRAM environment model plus a
// word-level reference memory that predicts what each access must do.
module tb_subservient_sram_ctrl;

    localparam int MEMSIZE = 512;
    localparam int AW      = 9;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [31:0]   a_adr, a_dat, b_adr, b_dat;
    logic [3:0]    a_sel, b_sel;
    logic          a_we, a_stb, b_we, b_stb;
    logic [31:0]   o_wb_a_rdt, o_wb_b_rdt;
    logic          o_wb_a_ack, o_wb_b_ack;
    logic [AW-1:0] o_sram_waddr, o_sram_raddr;
    logic [7:0]    o_sram_wdata;
    logic          o_sram_wen, o_sram_ren;
    logic [7:0]    i_sram_rdata = 8'h00;

    logic [7:0]    sram    [MEMSIZE];
    logic [7:0]    ref_mem [MEMSIZE];
    logic          sram_clr;

    int checks = 0;
    int errors = 0;

    subservient_sram_ctrl #(.memsize(MEMSIZE)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_wb_a_adr   (a_adr),
        .i_wb_a_dat   (a_dat),
        .i_wb_a_sel   (a_sel),
        .i_wb_a_we    (a_we),
        .i_wb_a_stb   (a_stb),
        .o_wb_a_rdt   (o_wb_a_rdt),
        .o_wb_a_ack   (o_wb_a_ack),
        .i_wb_b_adr   (b_adr),
        .i_wb_b_dat   (b_dat),
        .i_wb_b_sel   (b_sel),
        .i_wb_b_we    (b_we),
        .i_wb_b_stb   (b_stb),
        .o_wb_b_rdt   (o_wb_b_rdt),
        .o_wb_b_ack   (o_wb_b_ack),
        .o_sram_waddr (o_sram_waddr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_wen   (o_sram_wen),
        .o_sram_raddr (o_sram_raddr),
        .i_sram_rdata (i_sram_rdata),
        .o_sram_ren   (o_sram_ren)
    );

    always #5 i_clk = ~i_clk;

    // Byte SRAM with one-cycle read latency.
    always @(posedge i_clk) begin
        if (sram_clr) begin
            for (int i = 0; i < MEMSIZE; i++) sram[i] <= 8'h00;
        end else begin
            if (o_sram_wen) sram[o_sram_waddr] <= o_sram_wdata;
            if (o_sram_ren) i_sram_rdata <= sram[o_sram_raddr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_base(input logic [31:0] adr);
        return int'(adr & 32'(MEMSIZE - 1)) & ~3;
    endfunction

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // One access on one port; expectations come from the reference memory and fixed latencies.
    task automatic run_txn(input bit pb, input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input bit drop, output logic [31:0] rdt_out);
        int base, cyc, ack_cyc, exp_cyc;
        int wa[$];
        int ra[$];
        int ewa[$];
        logic [7:0] wd[$];
        logic [7:0] ewd[$];
        logic own, other;
        bit seen;
        base = word_base(adr);
        for (int i = 0; i < 4; i++) begin
            if (we && sel[i]) begin
                ewa.push_back(base + i);
                ewd.push_back(dat[8*i +: 8]);
            end
        end
        exp_cyc = we ? 5 : 6;
        rdt_out = 32'h0;
        @(negedge i_clk);
        if (pb) begin
            b_adr = adr; b_dat = dat; b_sel = sel; b_we = we; b_stb = 1'b1;
        end else begin
            a_adr = adr; a_dat = dat; a_sel = sel; a_we = we; a_stb = 1'b1;
        end
        cyc = 0; seen = 0; ack_cyc = -1;
        while (!seen && cyc < 12) begin
            @(negedge i_clk);
            cyc++;
            chk("wen_ren_exclusive", {31'b0, o_sram_wen & o_sram_ren}, 32'h0);
            if (o_sram_wen) begin
                wa.push_back(int'(o_sram_waddr));
                wd.push_back(o_sram_wdata);
            end
            if (o_sram_ren) ra.push_back(int'(o_sram_raddr));
            own   = pb ? o_wb_b_ack : o_wb_a_ack;
            other = pb ? o_wb_a_ack : o_wb_b_ack;
            chk("other_ack_low", {31'b0, other}, 32'h0);
            if (own) begin
                seen    = 1;
                ack_cyc = cyc;
                rdt_out = pb ? o_wb_b_rdt : o_wb_a_rdt;
            end
            if (own || (drop && cyc == 1)) begin
                if (pb) b_stb = 1'b0; else a_stb = 1'b0;
            end
        end
        a_stb = 1'b0;
        b_stb = 1'b0;
        chk("ack_cycle", 32'(ack_cyc), 32'(exp_cyc));
        chk("wen_count", 32'(wa.size()), 32'(ewa.size()));
        for (int i = 0; i < wa.size() && i < ewa.size(); i++) begin
            chk("waddr", 32'(wa[i]), 32'(ewa[i]));
            chk("wdata", {24'b0, wd[i]}, {24'b0, ewd[i]});
        end
        if (we) begin
            chk("ren_count_wr", 32'(ra.size()), 32'h0);
        end else begin
            chk("ren_count_rd", 32'(ra.size()), 32'd4);
            for (int i = 0; i < ra.size() && i < 4; i++) chk("raddr", 32'(ra[i]), 32'(base + i));
            chk("read_data", rdt_out, ref_word(base));
        end
        @(negedge i_clk);
        chk("ack_one_cycle", {30'b0, o_wb_a_ack, o_wb_b_ack}, 32'h0);
        for (int i = 0; i < ewa.size(); i++) ref_mem[ewa[i]] = ewd[i];
    endtask

    initial begin
        logic [31:0] rdt;
        logic [1:0]  exp_ack;
        int          a_cyc, b_cyc;
        logic [31:0] a_rdt, b_rdt;

        i_rst_n = 1'b0; sram_clr = 1'b1;
        a_adr = '0; a_dat = '0; a_sel = '0; a_we = 1'b0; a_stb = 1'b0;
        b_adr = '0; b_dat = '0; b_sel = '0; b_we = 1'b0; b_stb = 1'b0;
        for (int i = 0; i < MEMSIZE; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge i_clk);
        sram_clr = 1'b0;

        chk("rst_rdt_a", o_wb_a_rdt, 32'h0);
        chk("rst_rdt_b", o_wb_b_rdt, 32'h0);
        chk("rst_ctl", {28'b0, o_wb_a_ack, o_wb_b_ack, o_sram_wen, o_sram_ren}, 32'h0);
        chk("rst_waddr", {23'b0, o_sram_waddr}, 32'h0);
        chk("rst_raddr", {23'b0, o_sram_raddr}, 32'h0);
        chk("rst_wdata", {24'b0, o_sram_wdata}, 32'h0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("idle_ctl", {28'b0, o_wb_a_ack, o_wb_b_ack, o_sram_wen, o_sram_ren}, 32'h0);

        // Directed accesses
        run_txn(1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, 1'b0, rdt);
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rdt);
        chk("plan_read_0x10", rdt, 32'hA1B2C3D4);
        run_txn(1'b0, 1'b1, 32'h20, 32'hFFEEDDCC, 4'hF, 1'b0, rdt);
        run_txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'h5, 1'b0, rdt);
        run_txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rdt);
        chk("partial_preserve", rdt, 32'hFF22DD44);
        run_txn(1'b1, 1'b1, 32'h0000_0204, 32'hCAFEF00D, 4'hF, 1'b0, rdt);
        run_txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, rdt);
        chk("alias_read", rdt, 32'hCAFEF00D);
        run_txn(1'b0, 1'b1, 32'h30, 32'h01020304, 4'hF, 1'b1, rdt);
        run_txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, rdt);
        chk("drop_mid_read", rdt, 32'h01020304);

        // Both strobes held from reset: alternate A, B, A, B, 6 cycles per write
        @(negedge i_clk);
        i_rst_n = 1'b0;
        a_adr = 32'h40; a_dat = 32'h0A0B0C0D; a_sel = 4'hF; a_we = 1'b1; a_stb = 1'b1;
        b_adr = 32'h44; b_dat = 32'h50607080; b_sel = 4'hF; b_we = 1'b1; b_stb = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge i_clk);
            exp_ack = (c % 6 == 5) ? (((c / 6) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            chk("rr_ack", {30'b0, o_wb_a_ack, o_wb_b_ack}, {30'b0, exp_ack});
            if (c == 23) begin
                a_stb = 1'b0;
                b_stb = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[16'h40 + i] = a_dat[8*i +: 8];
            ref_mem[16'h44 + i] = b_dat[8*i +: 8];
        end
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, rdt);
        chk("rr_b_data", rdt, 32'h50607080);

        // Reset during the second write cycle
        @(negedge i_clk);
        a_adr = 32'h60; a_dat = 32'h55667788; a_sel = 4'hF; a_we = 1'b1; a_stb = 1'b1;
        @(negedge i_clk);
        chk("abort_first_wen", {31'b0, o_sram_wen}, 32'h1);
        @(posedge i_clk);
        #1;
        chk("abort_second_wen", {31'b0, o_sram_wen}, 32'h1);
        i_rst_n = 1'b0;
        a_stb = 1'b0;
        #1;
        chk("abort_ctl", {28'b0, o_wb_a_ack, o_wb_b_ack, o_sram_wen, o_sram_ren}, 32'h0);
        ref_mem[16'h60] = 8'h88;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        a_adr = 32'h60; a_we = 1'b0; a_stb = 1'b1;
        b_adr = 32'h10; b_we = 1'b0; b_stb = 1'b1;
        a_cyc = -1; b_cyc = -1; a_rdt = '0; b_rdt = '0;
        for (int c = 1; c <= 20 && b_cyc < 0; c++) begin
            @(negedge i_clk);
            chk("tie_ack_excl", {31'b0, o_wb_a_ack & o_wb_b_ack}, 32'h0);
            if (o_wb_a_ack) begin a_cyc = c; a_rdt = o_wb_a_rdt; a_stb = 1'b0; end
            if (o_wb_b_ack) begin b_cyc = c; b_rdt = o_wb_b_rdt; b_stb = 1'b0; end
        end
        a_stb = 1'b0;
        b_stb = 1'b0;
        chk("tie_a_first", 32'(a_cyc), 32'd6);
        chk("tie_b_second", 32'(b_cyc), 32'd13);
        chk("abort_bytes_kept", a_rdt, ref_word(16'h60));
        chk("tie_b_data", b_rdt, ref_word(16'h10));

        // Random accesses against the reference memory
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), rdt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
